// File: rtl/fir_kernel_ctrl_pkg.sv
// Shared types for the FIR kernel ap_ctrl_hs initiator: FSM state encoding and
// the flag bundle that the HWPE engine exposes to software.
package fir_kernel_ctrl_pkg;

  localparam int unsigned FIR_CNT_WIDTH     = 32;
  localparam int unsigned FIR_TIMEOUT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    ERR   = 2'd3
  } fir_ctrl_state_e;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic                     err_timeout;
    logic [FIR_CNT_WIDTH-1:0] in_cnt;
    logic [FIR_CNT_WIDTH-1:0] out_cnt;
  } fir_ctrl_flags_t;

endpackage

// File: rtl/fir_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles without stream activity and flags
// the cycle on which the count reaches the programmed threshold.
module fir_stall_watchdog #(
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     enable_i,
  input  logic                     activity_i,
  input  logic [TIMEOUT_WIDTH-1:0] threshold_i,
  output logic                     hit_o
);

  logic [TIMEOUT_WIDTH-1:0] cnt_q;
  logic [TIMEOUT_WIDTH:0]   cnt_inc;

  // The extra carry bit keeps an all-ones threshold reachable without wrapping.
  assign cnt_inc = {1'b0, cnt_q} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};

  assign hit_o = enable_i && !activity_i && (threshold_i != '0) &&
                 (cnt_inc == {1'b0, threshold_i});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i || !enable_i || activity_i) begin
      cnt_q <= '0;
    end else if (!cnt_inc[TIMEOUT_WIDTH]) begin
      cnt_q <= cnt_inc[TIMEOUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_kernel_ctrl.sv
// Initiator side of the HLS ap_ctrl_hs handshake for the FIR kernel: sequences
// ap_start, tracks stream beats and ap_done, and raises done/busy/error flags.
module fir_kernel_ctrl
  import fir_kernel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     start_i,
  input  logic [CNT_WIDTH-1:0]     len_i,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
  output logic                     ap_start_o,
  input  logic                     ap_ready_i,
  input  logic                     ap_done_i,
  input  logic                     ap_idle_i,
  input  logic                     in_valid_i,
  input  logic                     in_ready_i,
  input  logic                     out_valid_i,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_timeout_o,
  output logic [CNT_WIDTH-1:0]     in_cnt_o,
  output logic [CNT_WIDTH-1:0]     out_cnt_o,
  output logic [1:0]               state_o
);

  fir_ctrl_state_e          state_q;
  logic [CNT_WIDTH-1:0]     len_q;
  logic [TIMEOUT_WIDTH-1:0] timeout_q;
  logic                     done_seen_q;
  logic                     len_reached_q;

  logic                     in_beat;
  logic                     out_beat;
  logic [CNT_WIDTH-1:0]     in_cnt_nxt;
  logic [CNT_WIDTH-1:0]     out_cnt_nxt;
  logic                     len_hit;
  logic                     done_now;
  logic                     wd_hit;

  assign in_beat  = in_valid_i & in_ready_i;
  assign out_beat = out_valid_i & out_ready_i;

  // Input beats saturate; output beats wrap so late beats past len stay visible.
  assign in_cnt_nxt  = (in_beat && (in_cnt_o != '1)) ?
                       in_cnt_o + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : in_cnt_o;
  assign out_cnt_nxt = out_cnt_o + {{(CNT_WIDTH-1){1'b0}}, out_beat};

  assign len_hit  = len_reached_q || (out_cnt_nxt == len_q);
  assign done_now = done_seen_q || ap_done_i;
  assign state_o  = state_q;

  fir_stall_watchdog #(
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .enable_i   (state_q == RUN),
    .activity_i (in_beat | out_beat),
    .threshold_i(timeout_q),
    .hit_o      (wd_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ap_start_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      in_cnt_o      <= '0;
      out_cnt_o     <= '0;
      len_q         <= '0;
      timeout_q     <= '0;
      done_seen_q   <= 1'b0;
      len_reached_q <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (clear_i) begin
        state_q       <= IDLE;
        ap_start_o    <= 1'b0;
        busy_o        <= 1'b0;
        err_timeout_o <= 1'b0;
        in_cnt_o      <= '0;
        out_cnt_o     <= '0;
        done_seen_q   <= 1'b0;
        len_reached_q <= 1'b0;
      end else begin
        if (state_q == START || state_q == RUN) begin
          in_cnt_o      <= in_cnt_nxt;
          out_cnt_o     <= out_cnt_nxt;
          done_seen_q   <= done_now;
          len_reached_q <= len_hit;
        end
        case (state_q)
          IDLE, ERR: begin
            if (start_i) begin
              in_cnt_o      <= '0;
              out_cnt_o     <= '0;
              err_timeout_o <= 1'b0;
              done_seen_q   <= 1'b0;
              len_reached_q <= 1'b0;
              if (len_i != '0) begin
                state_q    <= START;
                busy_o     <= 1'b1;
                ap_start_o <= ap_idle_i;
                len_q      <= len_i;
                timeout_q  <= timeout_i;
              end else begin
                // An empty job completes immediately without waking the kernel.
                state_q <= IDLE;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end
            end
          end
          START: begin
            if (ap_start_o && ap_ready_i) begin
              state_q    <= RUN;
              ap_start_o <= 1'b0;
            end else if (!ap_start_o) begin
              ap_start_o <= ap_idle_i;
            end
          end
          RUN: begin
            if (len_hit && done_now) begin
              state_q <= IDLE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
            end else if (wd_hit) begin
              state_q       <= ERR;
              busy_o        <= 1'b0;
              err_timeout_o <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fir_kernel_ctrl.sv
// Scoreboard bench for fir_kernel_ctrl: stimulus pushes expected done/error
// events, a negedge monitor pops and compares them as the DUT raises them.
module tb_fir_kernel_ctrl;

  localparam int CW = 32;
  localparam int TW = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_i, start_i;
  logic [CW-1:0] len_i;
  logic [TW-1:0] timeout_i;
  logic          ap_start_o, ap_ready_i, ap_done_i, ap_idle_i;
  logic          in_valid_i, in_ready_i, out_valid_i, out_ready_i;
  logic          busy_o, done_o, err_timeout_o;
  logic [CW-1:0] in_cnt_o, out_cnt_o;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  fir_kernel_ctrl #(.CNT_WIDTH(CW), .TIMEOUT_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .timeout_i(timeout_i), .ap_start_o(ap_start_o),
    .ap_ready_i(ap_ready_i), .ap_done_i(ap_done_i), .ap_idle_i(ap_idle_i),
    .in_valid_i(in_valid_i), .in_ready_i(in_ready_i),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
    .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o), .state_o(state_o)
  );

  typedef struct {
    bit is_err;
    int cyc;
    bit chk_cnt;
    int out_cnt;
    int in_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic err_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushExp(input bit is_err, input int c, input bit chk, input int oc, input int ic);
    exp_t e;
    e.is_err = is_err; e.cyc = c; e.chk_cnt = chk; e.out_cnt = oc; e.in_cnt = ic;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse and every rising error edge must match the next expectation.
  always @(negedge clk) begin
    if (rst) begin
      err_prev <= 1'b0;
    end else begin
      if (done_o) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done: got done_o=1 at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("done_kind", 0, mon_e.is_err);
          checkOutput("done_cycle", cyc, mon_e.cyc);
          checkOutput("done_busy", busy_o, 0);
          if (mon_e.chk_cnt) begin
            checkOutput("done_out_cnt", out_cnt_o, mon_e.out_cnt);
            checkOutput("done_in_cnt", in_cnt_o, mon_e.in_cnt);
          end
        end
      end
      if (err_timeout_o && !err_prev) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_err: got err_timeout_o rise at cycle %0d, expected none", cyc);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("err_kind", 1, mon_e.is_err);
          checkOutput("err_cycle", cyc, mon_e.cyc);
          checkOutput("err_state", state_o, S_ERR);
          checkOutput("err_busy", busy_o, 0);
        end
      end
      err_prev <= err_timeout_o;
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    clear_i = 0; start_i = 0; ap_ready_i = 0; ap_done_i = 0; ap_idle_i = 1;
    in_valid_i = 0; in_ready_i = 0; out_valid_i = 0; out_ready_i = 0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      nextCycle();
      n++;
    end
    checkOutput("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ap_start"}, ap_start_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_done"}, done_o, 0);
    checkOutput({tag, "_err"}, err_timeout_o, 0);
    checkOutput({tag, "_in_cnt"}, in_cnt_o, 0);
    checkOutput({tag, "_out_cnt"}, out_cnt_o, 0);
    checkOutput({tag, "_state"}, state_o, S_IDLE);
  endtask

  task automatic startJob(input int len, input int tmo, input int ready_delay);
    start_i = 1; len_i = len; timeout_i = tmo[TW-1:0];
    nextCycle();
    start_i = 0; len_i = $urandom; timeout_i = TW'($urandom);
    checkOutput("ap_start_rise", ap_start_o, 1);
    checkOutput("start_state", state_o, S_START);
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_err_cleared", err_timeout_o, 0);
    for (int i = 0; i < ready_delay; i++) begin
      nextCycle();
      checkOutput("ap_start_hold", ap_start_o, 1);
    end
    ap_ready_i = 1;
    nextCycle();
    ap_ready_i = 0;
    checkOutput("ap_start_fall", ap_start_o, 0);
    checkOutput("run_state", state_o, S_RUN);
  endtask

  // done_pos: 0 = ap_done before any beat, 1..len = with that beat, len+1 = after the last beat.
  task automatic applyStimulus(input int len, input int tmo, input int ready_delay, input int done_pos);
    int out_sent, in_sent, gap, last_out;
    bit done_sent, ob, ib, db;
    startJob(len, tmo, ready_delay);
    out_sent = 0; in_sent = 0; gap = 0; last_out = cyc; done_sent = 0;
    while (!(out_sent == len && done_sent)) begin
      ib = ($urandom_range(0, 2) == 0);
      ob = (out_sent < len) && (gap >= 2 || $urandom_range(0, 1) == 1);
      db = 0;
      if (!done_sent) begin
        if (done_pos == 0) begin
          db = 1; ob = 0;
        end else if (done_pos <= len && ob && out_sent + 1 == done_pos) begin
          db = 1;
        end else if (done_pos > len && out_sent == len && cyc >= last_out + 2) begin
          db = 1;
        end
      end
      in_valid_i  = ib | ($urandom_range(0, 1) == 1);
      in_ready_i  = ib;
      out_valid_i = ob;
      out_ready_i = ob | ($urandom_range(0, 1) == 1);
      ap_done_i   = db;
      if (ob) begin out_sent++; last_out = cyc; gap = 0; end else gap++;
      if (ib) in_sent++;
      if (db) done_sent = 1;
      if (out_sent == len && done_sent) pushExp(0, cyc + 1, 1, len, in_sent);
      nextCycle();
    end
    idleInputs();
    waitDrain(10);
    checkOutput("idle_after_done", state_o, S_IDLE);
    checkOutput("busy_after_done", busy_o, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int t, last;
    idleInputs();
    len_i = '0; timeout_i = '0;
    #3;
    checkResetValues("reset");
    #10 rst = 0;
    nextCycle();

    // Fixed scenarios: ready at t+3 with ap_done on beat 4, then ap_done ahead of beats.
    applyStimulus(4, 0, 2, 4);
    applyStimulus(2, 0, $urandom_range(0, 3), 0);

    // Empty job.
    t = cyc;
    start_i = 1; len_i = 0; timeout_i = 5;
    pushExp(0, t + 1, 0, 0, 0);
    nextCycle();
    start_i = 0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("len0_ap_start", ap_start_o, 0);
      checkOutput("len0_busy", busy_o, 0);
      nextCycle();
    end
    waitDrain(4);

    // Stall after two beats with timeout 8.
    startJob(5, 8, 0);
    out_valid_i = 1; out_ready_i = 1;
    nextCycle();
    last = cyc;
    nextCycle();
    out_valid_i = 0; out_ready_i = 0;
    pushExp(1, last + 8 + 1, 0, 0, 0);
    waitDrain(30);
    checkOutput("stall_state", state_o, S_ERR);
    checkOutput("stall_busy", busy_o, 0);
    checkOutput("stall_err_sticky", err_timeout_o, 1);
    checkOutput("stall_out_cnt", out_cnt_o, 2);

    // Restart straight out of ERR.
    applyStimulus(3, 0, 1, $urandom_range(0, 4));

    // Clear mid-RUN, asserted together with a start.
    startJob(6, 0, 0);
    out_valid_i = 1; out_ready_i = 1;
    for (int i = 0; i < 3; i++) nextCycle();
    out_valid_i = 0; out_ready_i = 0;
    nextCycle();
    checkOutput("pre_clear_out_cnt", out_cnt_o, 3);
    clear_i = 1; start_i = 1; len_i = 7;
    nextCycle();
    clear_i = 0; start_i = 0;
    checkOutput("clear_state", state_o, S_IDLE);
    checkOutput("clear_out_cnt", out_cnt_o, 0);
    checkOutput("clear_ap_start", ap_start_o, 0);
    checkOutput("clear_busy", busy_o, 0);
    nextCycle();
    nextCycle();
    checkOutput("clear_stays_idle", state_o, S_IDLE);

    // Randomized jobs.
    for (int j = 0; j < 10; j++) begin
      int len;
      len = $urandom_range(1, 6);
      applyStimulus(len, ($urandom_range(0, 1) == 1) ? 30 : 0,
                    $urandom_range(0, 3), $urandom_range(0, len + 1));
    end

    // Repeated start during RUN is ignored; then async reset mid-RUN.
    startJob(3, 0, 0);
    start_i = 1; len_i = 1;
    nextCycle();
    nextCycle();
    start_i = 0;
    checkOutput("restart_ignored_state", state_o, S_RUN);
    checkOutput("restart_ignored_ap_start", ap_start_o, 0);
    checkOutput("restart_ignored_busy", busy_o, 1);
    #2 rst = 1;
    #1 checkResetValues("midrun_reset");
    #5 rst = 0;
    nextCycle();
    checkResetValues("post_reset");

    applyStimulus(2, 30, 1, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
